control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset  in  1  asynchronous, active-low reset (0 = reset).
REQ-003 SHALL have port OPCODE  in  6  instruction bits 31:26 from the instruction register.
REQ-004 SHALL have port FUNCT  in  6  instruction bits 5:0 (R-type function).
REQ-005 SHALL have port Overflow  in  1  ALU overflow flag, combinational.
REQ-006 SHALL have port Zero  in  1  ALU zero flag, combinational.
REQ-007 SHALL have port PCwrite  out  1  PC load enable.
REQ-008 SHALL have port MemWrite  out  1  memory write enable.
REQ-009 SHALL have port MemRead  out  1  memory data register load enable.
REQ-010 SHALL have port IRWrite  out  1  instruction register load enable.
REQ-011 SHALL have port RegWrite  out  1  register bank write enable.
REQ-012 SHALL have port MemToReg  out  1  write-data select (0 = ALUout, 1 = MDR).
REQ-013 SHALL have port RegDest  out  1  write-register select (0 = rt, 1 = rd).
REQ-014 SHALL have port AluSrcA  out  1  ALU A select (0 = PC, 1 = A).
REQ-015 SHALL have port AluSrcB  out  4  ALU B select (0 = B, 1 = constant 4, 2 = sign-extended, 3 = sign-extended<<2).
REQ-016 SHALL have port ALUControl  out  3  ALU operation (001 add, 010 sub, 011 and).
REQ-017 SHALL have port PCSource  out  4  PC source (0 = ALUResult, 1 = ALUout, 2 = jump address, 4 = exception vector).
REQ-018 SHALL have port IorD  out  1  memory address select (0 = PC, 1 = ALUout).
REQ-019 SHALL have port EPCWrite  out  1  EPC load enable.
REQ-020 SHALL have port State  out  5  current FSM state code (debug).

Function
REQ-021 SHALL be a Moore FSM; every output SHALL be 0 unless asserted by the current state. PCwrite in BRANCH is the only exception.
REQ-022 State codes SHALL be: 0 RESET, 1 FETCH1, 2 FETCH2, 3 DECODE, 4 EXEC_R, 5 WB_R, 6 EXEC_I, 7 WB_I, 8 ADDR, 9 LW_REQ, 10 LW_WAIT, 11 LW_WB, 12 SW_WR, 13 BRANCH, 14 JUMP, 15 EXC1, 16 EXC2.
REQ-023 RESET SHALL transition unconditionally to FETCH1.
REQ-024 FETCH1 SHALL assert IorD=0 and go to FETCH2.
REQ-025 FETCH2 SHALL assert IRWrite=1, AluSrcA=0, AluSrcB=1, ALUControl=001, PCSource=0, PCwrite=1, then go to DECODE.
REQ-026 DECODE SHALL compute the branch target (AluSrcA=0, AluSrcB=3, ALUControl=001) and dispatch on OPCODE:
- 0x00 with FUNCT 0x20/0x22/0x24 -> EXEC_R.
- 0x08 -> EXEC_I.
- 0x23/0x2B -> ADDR.
- 0x04/0x05 -> BRANCH.
- 0x02 -> JUMP.
- anything else -> EXC1.
REQ-027 EXEC_R SHALL set AluSrcA=1, AluSrcB=0, ALUControl=001/010/011 for add/sub/and. It SHALL go to EXC1 if Overflow=1 and FUNCT is add or sub, else to WB_R.
REQ-028 WB_R SHALL assert RegWrite=1, RegDest=1, MemToReg=0, then go to FETCH1.
REQ-029 EXEC_I SHALL set AluSrcA=1, AluSrcB=2, ALUControl=001. It SHALL go to EXC1 if Overflow=1, else to WB_I. WB_I SHALL assert RegWrite=1, RegDest=0, MemToReg=0.
REQ-030 ADDR SHALL set AluSrcA=1, AluSrcB=2, ALUControl=001, then go to LW_REQ (0x23) or SW_WR (0x2B).
REQ-031 LW_REQ SHALL assert IorD=1. LW_WAIT SHALL assert IorD=1 and MemRead=1. LW_WB SHALL assert RegWrite=1, MemToReg=1, RegDest=0.
REQ-032 SW_WR SHALL assert IorD=1 and MemWrite=1 for exactly one cycle, then go to FETCH1.
REQ-033 BRANCH SHALL set AluSrcA=1, AluSrcB=0, ALUControl=010, PCSource=1. It SHALL drive PCwrite=Zero for 0x04 and PCwrite=~Zero for 0x05.
REQ-034 JUMP SHALL assert PCSource=2 and PCwrite=1.
REQ-035 EXC1 SHALL compute PC-4 (AluSrcA=0, AluSrcB=1, ALUControl=010). EXC2 SHALL assert EPCWrite=1, PCSource=4, PCwrite=1.
REQ-036 Required latencies, FETCH1 to next FETCH1:
- R-type and addi: 5 cycles.
- lw: 7 cycles.
- sw: 5 cycles.
- beq/bne/j: 4 cycles.
- exception: DECODE/EXEC, then 2 cycles.
REQ-037 An overflowing instruction SHALL never assert RegWrite.

Reset
REQ-038 reset=0 SHALL immediately, independent of clk, force State=RESET and all outputs to 0, including mid-instruction.
REQ-039 After reset rises, the first rising edge SHALL move RESET to FETCH1.

Verification
REQ-040 Drive reset=0 during LW_WAIT -> all outputs 0 and State=0 without a clock edge; release -> State=1 after one edge.
REQ-041 Run OPCODE=0x00, FUNCT=0x20, Overflow=0 -> State sequence 1,2,3,4,5,1; RegWrite=1 with RegDest=1 only in state 5; PCwrite only in state 2.
REQ-042 Run the same add with Overflow=1 in EXEC_R -> sequence 4,15,16,1; RegWrite never 1; EPCWrite=1, PCwrite=1, PCSource=4 in state 16.
REQ-043 Run OPCODE=0x04 with Zero=0 -> PCwrite=0 in BRANCH. Run OPCODE=0x05 with Zero=0 -> PCwrite=1 and PCSource=1 in BRANCH.
REQ-044 Run OPCODE=0x23 -> sequence 1,2,3,8,9,10,11,1; MemRead=1 only in state 10; IorD=1 in states 9 and 10; MemToReg=1 in state 11.
REQ-045 Run OPCODE=0x3F, and separately OPCODE=0x00 with FUNCT=0x3F -> sequence 3,15,16,1 with no RegWrite or MemWrite.

Source files
------------

// File: rtl/control_unit.sv
// Multicycle MIPS-subset control unit: Moore FSM sequencing fetch, decode,
// execute, memory, write-back and exception entry, with state exported for debug.
module control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OPCODE,
    input  logic [5:0] FUNCT,
    input  logic       Overflow,
    input  logic       Zero,
    output logic       PCwrite,
    output logic       MemWrite,
    output logic       MemRead,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemToReg,
    output logic       RegDest,
    output logic       AluSrcA,
    output logic [3:0] AluSrcB,
    output logic [2:0] ALUControl,
    output logic [3:0] PCSource,
    output logic       IorD,
    output logic       EPCWrite,
    output logic [4:0] State
);

    localparam int unsigned STW = 5;
    localparam int unsigned OPW = 6;

    localparam logic [OPW-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPW-1:0] OP_J     = 6'h02;
    localparam logic [OPW-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPW-1:0] OP_BNE   = 6'h05;
    localparam logic [OPW-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPW-1:0] OP_LW    = 6'h23;
    localparam logic [OPW-1:0] OP_SW    = 6'h2B;

    localparam logic [OPW-1:0] F_ADD = 6'h20;
    localparam logic [OPW-1:0] F_SUB = 6'h22;
    localparam logic [OPW-1:0] F_AND = 6'h24;

    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;

    typedef enum logic [STW-1:0] {
        S_RESET   = 5'd0,
        S_FETCH1  = 5'd1,
        S_FETCH2  = 5'd2,
        S_DECODE  = 5'd3,
        S_EXEC_R  = 5'd4,
        S_WB_R    = 5'd5,
        S_EXEC_I  = 5'd6,
        S_WB_I    = 5'd7,
        S_ADDR    = 5'd8,
        S_LW_REQ  = 5'd9,
        S_LW_WAIT = 5'd10,
        S_LW_WB   = 5'd11,
        S_SW_WR   = 5'd12,
        S_BRANCH  = 5'd13,
        S_JUMP    = 5'd14,
        S_EXC1    = 5'd15,
        S_EXC2    = 5'd16
    } state_t;

    state_t state;
    state_t next_state;
    logic   funct_valid;
    logic   funct_arith;

    assign funct_valid = (FUNCT == F_ADD) || (FUNCT == F_SUB) || (FUNCT == F_AND);
    assign funct_arith = (FUNCT == F_ADD) || (FUNCT == F_SUB);
    assign State       = STW'(state);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_RESET;
        else        state <= next_state;
    end

    // Moore decode; RESET drives all-zero so async reset clears outputs at once
    always_comb begin
        next_state = state;
        PCwrite    = 1'b0;
        MemWrite   = 1'b0;
        MemRead    = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemToReg   = 1'b0;
        RegDest    = 1'b0;
        AluSrcA    = 1'b0;
        AluSrcB    = 4'd0;
        ALUControl = 3'b000;
        PCSource   = 4'd0;
        IorD       = 1'b0;
        EPCWrite   = 1'b0;
        case (state)
            S_RESET:  next_state = S_FETCH1;
            S_FETCH1: next_state = S_FETCH2;
            S_FETCH2: begin
                IRWrite    = 1'b1;
                AluSrcB    = 4'd1;
                ALUControl = ALU_ADD;
                PCwrite    = 1'b1;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                AluSrcB    = 4'd3;
                ALUControl = ALU_ADD;
                case (OPCODE)
                    OP_RTYPE:      next_state = funct_valid ? S_EXEC_R : S_EXC1;
                    OP_ADDI:       next_state = S_EXEC_I;
                    OP_LW, OP_SW:  next_state = S_ADDR;
                    OP_BEQ, OP_BNE: next_state = S_BRANCH;
                    OP_J:          next_state = S_JUMP;
                    default:       next_state = S_EXC1;
                endcase
            end
            S_EXEC_R: begin
                AluSrcA = 1'b1;
                case (FUNCT)
                    F_ADD:   ALUControl = ALU_ADD;
                    F_SUB:   ALUControl = ALU_SUB;
                    F_AND:   ALUControl = ALU_AND;
                    default: ALUControl = 3'b000;
                endcase
                next_state = (Overflow && funct_arith) ? S_EXC1 : S_WB_R;
            end
            S_WB_R: begin
                RegWrite   = 1'b1;
                RegDest    = 1'b1;
                next_state = S_FETCH1;
            end
            S_EXEC_I: begin
                AluSrcA    = 1'b1;
                AluSrcB    = 4'd2;
                ALUControl = ALU_ADD;
                next_state = Overflow ? S_EXC1 : S_WB_I;
            end
            S_WB_I: begin
                RegWrite   = 1'b1;
                next_state = S_FETCH1;
            end
            S_ADDR: begin
                AluSrcA    = 1'b1;
                AluSrcB    = 4'd2;
                ALUControl = ALU_ADD;
                next_state = (OPCODE == OP_LW) ? S_LW_REQ : S_SW_WR;
            end
            S_LW_REQ: begin
                IorD       = 1'b1;
                next_state = S_LW_WAIT;
            end
            S_LW_WAIT: begin
                IorD       = 1'b1;
                MemRead    = 1'b1;
                next_state = S_LW_WB;
            end
            S_LW_WB: begin
                RegWrite   = 1'b1;
                MemToReg   = 1'b1;
                next_state = S_FETCH1;
            end
            S_SW_WR: begin
                IorD       = 1'b1;
                MemWrite   = 1'b1;
                next_state = S_FETCH1;
            end
            // only output that depends on an input: taken/not-taken from Zero
            S_BRANCH: begin
                AluSrcA    = 1'b1;
                ALUControl = ALU_SUB;
                PCSource   = 4'd1;
                PCwrite    = (OPCODE == OP_BNE) ? ~Zero : Zero;
                next_state = S_FETCH1;
            end
            S_JUMP: begin
                PCSource   = 4'd2;
                PCwrite    = 1'b1;
                next_state = S_FETCH1;
            end
            S_EXC1: begin
                AluSrcB    = 4'd1;
                ALUControl = ALU_SUB;
                next_state = S_EXC2;
            end
            S_EXC2: begin
                EPCWrite   = 1'b1;
                PCSource   = 4'd4;
                PCwrite    = 1'b1;
                next_state = S_FETCH1;
            end
            default: next_state = S_RESET;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks each instruction class state by state
// and compares state code and the full output word against hand-written values.
module tb_control_unit;

    logic       clk;
    logic       reset;
    logic [5:0] OPCODE;
    logic [5:0] FUNCT;
    logic       Overflow;
    logic       Zero;
    logic       PCwrite, MemWrite, MemRead, IRWrite, RegWrite, MemToReg, RegDest, AluSrcA;
    logic [3:0] AluSrcB;
    logic [2:0] ALUControl;
    logic [3:0] PCSource;
    logic       IorD, EPCWrite;
    logic [4:0] State;
    logic [20:0] outs;

    int passed = 0;
    int total  = 0;

    control_unit dut (
        .clk(clk), .reset(reset), .OPCODE(OPCODE), .FUNCT(FUNCT),
        .Overflow(Overflow), .Zero(Zero), .PCwrite(PCwrite), .MemWrite(MemWrite),
        .MemRead(MemRead), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemToReg(MemToReg),
        .RegDest(RegDest), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .ALUControl(ALUControl),
        .PCSource(PCSource), .IorD(IorD), .EPCWrite(EPCWrite), .State(State)
    );

    assign outs = {PCwrite, MemWrite, MemRead, IRWrite, RegWrite, MemToReg, RegDest,
                   AluSrcA, AluSrcB, ALUControl, PCSource, IorD, EPCWrite};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [20:0] ov(input logic pcw, mw, mr, irw, rw, m2r, rd, asa,
                                       input logic [3:0] asb, input logic [2:0] alu,
                                       input logic [3:0] pcs, input logic iord, epc);
        return {pcw, mw, mr, irw, rw, m2r, rd, asa, asb, alu, pcs, iord, epc};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // check current state and outputs, then advance one clock
    task automatic st(input string tag, input logic [4:0] es, input logic [20:0] eo);
        chk({tag, " state"}, 32'(State), 32'(es));
        chk({tag, " outs"}, 32'(outs), 32'(eo));
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [5:0] op, input logic [5:0] fn, input logic ovf, input logic z);
        OPCODE   = op;
        FUNCT    = fn;
        Overflow = ovf;
        Zero     = z;
    endtask

    initial begin : stim
        logic [20:0] o_z, o_f2, o_dec, o_wbr, o_exi, o_wbi, o_lwreq, o_lwwait, o_lwwb;
        logic [20:0] o_sw, o_j, o_e1, o_e2;
        o_z      = ov(0,0,0,0,0,0,0,0, 4'd0, 3'd0, 4'd0, 0,0);
        o_f2     = ov(1,0,0,1,0,0,0,0, 4'd1, 3'd1, 4'd0, 0,0);
        o_dec    = ov(0,0,0,0,0,0,0,0, 4'd3, 3'd1, 4'd0, 0,0);
        o_wbr    = ov(0,0,0,0,1,0,1,0, 4'd0, 3'd0, 4'd0, 0,0);
        o_exi    = ov(0,0,0,0,0,0,0,1, 4'd2, 3'd1, 4'd0, 0,0);
        o_wbi    = ov(0,0,0,0,1,0,0,0, 4'd0, 3'd0, 4'd0, 0,0);
        o_lwreq  = ov(0,0,0,0,0,0,0,0, 4'd0, 3'd0, 4'd0, 1,0);
        o_lwwait = ov(0,0,1,0,0,0,0,0, 4'd0, 3'd0, 4'd0, 1,0);
        o_lwwb   = ov(0,0,0,0,1,1,0,0, 4'd0, 3'd0, 4'd0, 0,0);
        o_sw     = ov(0,1,0,0,0,0,0,0, 4'd0, 3'd0, 4'd0, 1,0);
        o_j      = ov(1,0,0,0,0,0,0,0, 4'd0, 3'd0, 4'd2, 0,0);
        o_e1     = ov(0,0,0,0,0,0,0,0, 4'd1, 3'd2, 4'd0, 0,0);
        o_e2     = ov(1,0,0,0,0,0,0,0, 4'd0, 3'd0, 4'd4, 0,1);

        reset = 1'b0;
        set_in(6'h00, 6'h20, 1'b0, 1'b0);
        #3;
        chk("reset state", 32'(State), 32'd0);
        chk("reset outs", 32'(outs), 32'(o_z));
        @(posedge clk);
        #1;
        chk("reset hold state", 32'(State), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // add, no overflow
        st("add f1", 5'd1, o_z);
        st("add f2", 5'd2, o_f2);
        st("add dec", 5'd3, o_dec);
        st("add exr", 5'd4, ov(0,0,0,0,0,0,0,1, 4'd0, 3'd1, 4'd0, 0,0));
        st("add wbr", 5'd5, o_wbr);

        // add with overflow -> exception, no register write
        set_in(6'h00, 6'h20, 1'b1, 1'b0);
        st("addov f1", 5'd1, o_z);
        st("addov f2", 5'd2, o_f2);
        st("addov dec", 5'd3, o_dec);
        st("addov exr", 5'd4, ov(0,0,0,0,0,0,0,1, 4'd0, 3'd1, 4'd0, 0,0));
        st("addov exc1", 5'd15, o_e1);
        st("addov exc2", 5'd16, o_e2);

        // sub with overflow also traps
        set_in(6'h00, 6'h22, 1'b1, 1'b0);
        st("subov f1", 5'd1, o_z);
        st("subov f2", 5'd2, o_f2);
        st("subov dec", 5'd3, o_dec);
        st("subov exr", 5'd4, ov(0,0,0,0,0,0,0,1, 4'd0, 3'd2, 4'd0, 0,0));
        st("subov exc1", 5'd15, o_e1);
        st("subov exc2", 5'd16, o_e2);

        // and ignores overflow
        set_in(6'h00, 6'h24, 1'b1, 1'b0);
        st("and f1", 5'd1, o_z);
        st("and f2", 5'd2, o_f2);
        st("and dec", 5'd3, o_dec);
        st("and exr", 5'd4, ov(0,0,0,0,0,0,0,1, 4'd0, 3'd3, 4'd0, 0,0));
        st("and wbr", 5'd5, o_wbr);

        // addi no overflow, then addi overflow
        set_in(6'h08, 6'h00, 1'b0, 1'b0);
        st("addi f1", 5'd1, o_z);
        st("addi f2", 5'd2, o_f2);
        st("addi dec", 5'd3, o_dec);
        st("addi exi", 5'd6, o_exi);
        st("addi wbi", 5'd7, o_wbi);
        set_in(6'h08, 6'h00, 1'b1, 1'b0);
        st("addiov f1", 5'd1, o_z);
        st("addiov f2", 5'd2, o_f2);
        st("addiov dec", 5'd3, o_dec);
        st("addiov exi", 5'd6, o_exi);
        st("addiov exc1", 5'd15, o_e1);
        st("addiov exc2", 5'd16, o_e2);

        // beq not taken, beq taken, bne taken
        set_in(6'h04, 6'h00, 1'b0, 1'b0);
        st("beq0 f1", 5'd1, o_z);
        st("beq0 f2", 5'd2, o_f2);
        st("beq0 dec", 5'd3, o_dec);
        st("beq0 br", 5'd13, ov(0,0,0,0,0,0,0,1, 4'd0, 3'd2, 4'd1, 0,0));
        set_in(6'h04, 6'h00, 1'b0, 1'b1);
        st("beq1 f1", 5'd1, o_z);
        st("beq1 f2", 5'd2, o_f2);
        st("beq1 dec", 5'd3, o_dec);
        st("beq1 br", 5'd13, ov(1,0,0,0,0,0,0,1, 4'd0, 3'd2, 4'd1, 0,0));
        set_in(6'h05, 6'h00, 1'b0, 1'b0);
        st("bne0 f1", 5'd1, o_z);
        st("bne0 f2", 5'd2, o_f2);
        st("bne0 dec", 5'd3, o_dec);
        st("bne0 br", 5'd13, ov(1,0,0,0,0,0,0,1, 4'd0, 3'd2, 4'd1, 0,0));

        // jump
        set_in(6'h02, 6'h00, 1'b0, 1'b0);
        st("j f1", 5'd1, o_z);
        st("j f2", 5'd2, o_f2);
        st("j dec", 5'd3, o_dec);
        st("j jmp", 5'd14, o_j);

        // lw
        set_in(6'h23, 6'h00, 1'b0, 1'b0);
        st("lw f1", 5'd1, o_z);
        st("lw f2", 5'd2, o_f2);
        st("lw dec", 5'd3, o_dec);
        st("lw addr", 5'd8, o_exi);
        st("lw req", 5'd9, o_lwreq);
        st("lw wait", 5'd10, o_lwwait);
        st("lw wb", 5'd11, o_lwwb);

        // sw
        set_in(6'h2B, 6'h00, 1'b0, 1'b0);
        st("sw f1", 5'd1, o_z);
        st("sw f2", 5'd2, o_f2);
        st("sw dec", 5'd3, o_dec);
        st("sw addr", 5'd8, o_exi);
        st("sw wr", 5'd12, o_sw);

        // illegal opcode, then illegal funct
        set_in(6'h3F, 6'h00, 1'b0, 1'b0);
        st("ilop f1", 5'd1, o_z);
        st("ilop f2", 5'd2, o_f2);
        st("ilop dec", 5'd3, o_dec);
        st("ilop exc1", 5'd15, o_e1);
        st("ilop exc2", 5'd16, o_e2);
        set_in(6'h00, 6'h3F, 1'b0, 1'b0);
        st("ilfn f1", 5'd1, o_z);
        st("ilfn f2", 5'd2, o_f2);
        st("ilfn dec", 5'd3, o_dec);
        st("ilfn exc1", 5'd15, o_e1);
        st("ilfn exc2", 5'd16, o_e2);

        // async reset during LW_WAIT
        set_in(6'h23, 6'h00, 1'b0, 1'b0);
        st("lwr f1", 5'd1, o_z);
        st("lwr f2", 5'd2, o_f2);
        st("lwr dec", 5'd3, o_dec);
        st("lwr addr", 5'd8, o_exi);
        st("lwr req", 5'd9, o_lwreq);
        chk("lwr wait state", 32'(State), 32'd10);
        chk("lwr wait outs", 32'(outs), 32'(o_lwwait));
        reset = 1'b0;
        #1;
        chk("async rst state", 32'(State), 32'd0);
        chk("async rst outs", 32'(outs), 32'(o_z));
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("post rst state", 32'(State), 32'd1);
        chk("post rst outs", 32'(outs), 32'(o_z));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
